// File: rtl/led_pkg.sv
// led_pkg: shared state encoding and default sizing for the LED pattern generator.
package led_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam int LED_CLK_DIV_DEF = 4;
    localparam int LED_PAT_W_DEF   = 8;
    localparam int LED_REP_W_DEF   = 4;
    localparam int LED_PWM_W       = 4;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: one-cycle tick every CLK_DIV cycles, phase restarted by clr.
module led_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk)
        if (rst || clr) r_cnt <= '0;
        else            r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: plays a latched blink pattern MSB-first on led, N times or forever.
// LED_PWM_EN adds a latched duty input that dims led with a free-running 4-bit pwm counter.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_DIV = LED_CLK_DIV_DEF,
    parameter int PAT_W   = LED_PAT_W_DEF,
    parameter int REP_W   = LED_REP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [PAT_W-1:0]     pat_data,
    input  logic [REP_W-1:0]     pat_reps,
    input  logic                 stop,
`ifdef LED_PWM_EN
    input  logic [LED_PWM_W-1:0] duty,
`endif
    output logic                 led,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = $clog2(PAT_W);
    state_t           r_state, w_state_n;
    logic [PAT_W-1:0] r_pat, w_pat_n;
    logic [REP_W-1:0] r_reps, w_reps_n, r_rep_cnt, w_rep_cnt_n;
    logic [IW-1:0]    r_idx, w_idx_n;
    logic             r_led, w_led_n, w_accept, w_tick, w_pwm_on;
    assign w_accept = r_state == IDLE && pat_valid;
    assign led      = r_led;
    led_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .tick(w_tick)
    );
`ifdef LED_PWM_EN
    logic [LED_PWM_W-1:0] r_pwm, r_duty, w_duty_n, w_pwm_n;
    assign w_pwm_n  = r_pwm + 1'b1;
    assign w_duty_n = w_accept ? duty : r_duty;
    // led is registered, so compare against the counter and duty of the cycle being driven
    assign w_pwm_on = w_pwm_n < w_duty_n;
    always_ff @(posedge clk)
        if (rst) begin
            r_pwm  <= '0;
            r_duty <= '0;
        end else begin
            r_pwm  <= w_pwm_n;
            r_duty <= w_duty_n;
        end
`else
    assign w_pwm_on = 1'b1;
`endif
    always_ff @(posedge clk)
        if (rst) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_reps    <= '0;
            r_rep_cnt <= '0;
            r_idx     <= '0;
            r_led     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pat     <= w_pat_n;
            r_reps    <= w_reps_n;
            r_rep_cnt <= w_rep_cnt_n;
            r_idx     <= w_idx_n;
            r_led     <= w_led_n;
        end
    always_comb begin
        w_state_n   = r_state;
        w_pat_n     = r_pat;
        w_reps_n    = r_reps;
        w_rep_cnt_n = r_rep_cnt;
        w_idx_n     = r_idx;
        if (w_accept) begin
            w_state_n   = PLAY;
            w_pat_n     = pat_data;
            w_reps_n    = pat_reps;
            w_rep_cnt_n = pat_reps;
            w_idx_n     = IW'(PAT_W - 1);
        end else if (r_state == DONE) begin
            w_state_n = IDLE;
        end else if (r_state == PLAY) begin
            if (stop) begin
                w_state_n = IDLE;
            end else if (w_tick) begin
                if (r_idx != '0) begin
                    w_idx_n = r_idx - 1'b1;
                end else if (r_reps == '0) begin
                    w_idx_n = IW'(PAT_W - 1);
                end else if (r_rep_cnt == REP_W'(1)) begin
                    w_state_n = DONE;
                end else begin
                    w_rep_cnt_n = r_rep_cnt - 1'b1;
                    w_idx_n     = IW'(PAT_W - 1);
                end
            end
        end
    end
    always_comb begin
        pat_ready = r_state == IDLE;
        busy      = r_state == PLAY;
        done      = r_state == DONE;
        w_led_n   = w_state_n == PLAY && w_pat_n[w_idx_n] && w_pwm_on;
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: drives a CLK_DIV=4 and a CLK_DIV=1 instance in lockstep and checks
// every output, every cycle, against a timeline model built from elapsed cycles since handshake.
module tb_led_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pat_valid = 1'b0;
    logic [7:0] pat_data = '0;
    logic [3:0] pat_reps = '0;
    logic       stop = 1'b0;
`ifdef LED_PWM_EN
    logic [3:0] duty = '0;
`endif
    logic [1:0] led_w, busy_w, done_w, rdy_w;
    int n_chk = 0, n_fail = 0, cyc = 0, last_rst = -1;
    int div[2] = '{4, 1};
    bit act[2];
    int t0[2], mreps[2], mduty[2];
    logic [7:0] mpat[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        led_pattern_gen #(.CLK_DIV(g == 0 ? 4 : 1), .PAT_W(8), .REP_W(4)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .pat_valid(pat_valid),
            .pat_ready(rdy_w[g]),
            .pat_data (pat_data),
            .pat_reps (pat_reps),
            .stop     (stop),
`ifdef LED_PWM_EN
            .duty     (duty),
`endif
            .led      (led_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // one clock: apply inputs, check this cycle's outputs, advance the model across the edge
    task automatic step(input logic v, input logic [7:0] d, input logic [3:0] r,
                        input logic s, input logic rs, input logic [3:0] du);
        @(negedge clk);
        pat_valid = v;
        pat_data  = d;
        pat_reps  = r;
        stop      = s;
        rst       = rs;
`ifdef LED_PWM_EN
        duty      = du;
`endif
        for (int i = 0; i < 2; i++) begin
            int e, tot;
            logic pwm_ok;
            logic [3:0] exp;
            e      = cyc - t0[i] - 1;
            tot    = mreps[i] * 8 * div[i];
            pwm_ok = 1'b1;
`ifdef LED_PWM_EN
            pwm_ok = ((cyc - last_rst - 1) % 16) < mduty[i];
`endif
            if (!act[i])                          exp = 4'b1000;
            else if (mreps[i] != 0 && e == tot)   exp = 4'b0010;
            else exp = {3'b010, mpat[i][7 - (e / div[i]) % 8] & pwm_ok};
            chk($sformatf("u%0d.pat_ready", i), rdy_w[i],  exp[3]);
            chk($sformatf("u%0d.busy", i),      busy_w[i], exp[2]);
            chk($sformatf("u%0d.done", i),      done_w[i], exp[1]);
            chk($sformatf("u%0d.led", i),       led_w[i],  exp[0]);
            if (rs) act[i] = 0;
            else if (!act[i]) begin
                if (v) begin
                    act[i]   = 1;
                    t0[i]    = cyc;
                    mpat[i]  = d;
                    mreps[i] = r;
                    mduty[i] = du;
                end
            end else if (mreps[i] != 0 && e == tot) act[i] = 0;
            else if (s) act[i] = 0;
        end
        if (rs) last_rst = cyc;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 8'h00, 4'd0, 0, 0, 4'd0);
    endtask

    task automatic go(input logic [7:0] d, input logic [3:0] r, input logic [3:0] du);
        step(0, 8'h00, 4'd0, 1, 0, 4'd0);
        step(1, d, r, 0, 0, du);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // reset mid-play
        go(8'hA3, 4'd1, 4'd15);
        run(10);
        repeat (3) step(0, 8'h00, 4'd0, 0, 1, 4'd0);
        run(2);
        // single play, then pat_ready returns
        go(8'b1010_0011, 4'd1, 4'd15);
        run(40);
        // three repeats with pat_valid held during busy
        go(8'hF0, 4'd3, 4'd15);
        repeat (95) step(1, 8'($urandom), 4'($urandom_range(1, 3)), 0, 0, 4'd15);
        run(30);
        // endless loop, then stop
        go(8'h81, 4'd0, 4'd15);
        run(5 * 32 + 7);
        step(0, 8'h00, 4'd0, 1, 0, 4'd0);
        run(3);
        // all-ones across wraps, and stop coincident with final step on each instance
        go(8'hFF, 4'd2, 4'd15);
        run(70);
        go(8'hA5, 4'd1, 4'd15);
        run(31);
        step(0, 8'h00, 4'd0, 1, 0, 4'd0);
        run(3);
        go(8'h3C, 4'd1, 4'd15);
        run(7);
        step(0, 8'h00, 4'd0, 1, 0, 4'd0);
        run(3);
        // all-zero pattern, then duty patterns (no dimming when the pwm feature is absent)
        go(8'h00, 4'd1, 4'd15);
        run(36);
        go(8'hFF, 4'd2, 4'd4);
        run(70);
        go(8'hFF, 4'd2, 4'd0);
        run(70);
        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            go(8'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
            repeat ($urandom_range(20, 150))
                step(1'($urandom_range(0, 7) == 0), 8'($urandom), 4'($urandom_range(0, 3)),
                     1'($urandom_range(0, 63) == 0), 0, 4'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
